riscv_elastic_pipe: RTL and testbench

- Parametrised elastic pipeline-register chain. It replaces the bare per-field pipeline registers between core stages (IF->ID, ID->EX, EX->MEM/WB).
- Each stage carries a valid bit and uses valid/ready handshakes on both ends.
- Bubbles collapse: a valid entry advances whenever the stage ahead is empty or draining.
- Global stall freezes the whole chain; flush kills every in-flight entry. Sits between any two core stages, including on the dcache stall path.

---
 rtl/riscv_elastic_pipe.sv | 121 ++++++++++++
 tb/tb_riscv_elastic_pipe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_elastic_pipe.sv
`default_nettype none
// riscv_elastic_pipe (rev 1.0): elastic valid/ready register chain with global stall and flush.
// Optional per-stage even parity and parity_err output when RISCV_PIPE_PARITY_EN is defined.
module riscv_elastic_pipe #(
  parameter int               WIDTH     = 32,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        stall,
  input  logic                        flush,
`ifdef RISCV_PIPE_PARITY_EN
  output logic                        parity_err,
`endif
  output logic [$clog2(STAGES+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(STAGES+1);
  localparam int LAST  = STAGES - 1;

  logic [WIDTH-1:0]  data_q   [STAGES];
  logic [WIDTH-1:0]  src_data [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] adv;
  logic [STAGES:0]   adv_chain;
  logic [OCC_W-1:0]  occ_d;
  logic              run;

  assign run = !stall && !flush;

  // Advance ripples from the output end back toward the input.
  always_comb begin
    adv_chain         = '0;
    adv_chain[STAGES] = out_ready;
    for (int i = LAST; i >= 0; i--) begin
      adv_chain[i] = run && (!valid_q[i] || adv_chain[i+1]);
    end
  end

  assign adv = adv_chain[LAST:0];

  for (genvar g = 0; g < STAGES; g++) begin : g_src
    if (g == 0) begin : g_head
      assign src_valid[g] = in_valid;
      assign src_data[g]  = in_data;
    end else begin : g_link
      assign src_valid[g] = valid_q[g-1];
      assign src_data[g]  = data_q[g-1];
    end
  end

  always_comb begin
    valid_d = '0;
    occ_d   = '0;
    for (int i = 0; i < STAGES; i++) begin
      valid_d[i] = flush ? 1'b0 : (adv[i] ? src_valid[i] : valid_q[i]);
      occ_d      = occ_d + OCC_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= '0;
      occupancy <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      valid_q   <= valid_d;
      occupancy <= occ_d;
      for (int i = 0; i < STAGES; i++) begin
        if (adv[i]) begin
          data_q[i] <= src_data[i];
        end
      end
    end
  end

  assign in_ready  = reset && adv[0];
  assign out_valid = valid_q[LAST] && !flush;
  assign out_data  = data_q[LAST];

`ifdef RISCV_PIPE_PARITY_EN
  logic [STAGES-1:0] par_q;
  logic [STAGES-1:0] src_par;

  for (genvar g = 0; g < STAGES; g++) begin : g_par
    if (g == 0) begin : g_head
      assign src_par[g] = ^in_data;
    end else begin : g_link
      assign src_par[g] = par_q[g-1];
    end
  end

  // Parity bit is captured once at entry and moves in lockstep with its payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q      <= {STAGES{^RESET_VAL}};
      parity_err <= 1'b0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (adv[i]) begin
          par_q[i] <= src_par[i];
        end
      end
      parity_err <= valid_q[LAST] && !flush && ((^data_q[LAST]) != par_q[LAST]);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_elastic_pipe.sv
`default_nettype none
// tb_riscv_elastic_pipe: scoreboard-based bench for the elastic pipeline chain (STAGES=3, WIDTH=32).
module tb_riscv_elastic_pipe;

  localparam int          W  = 32;
  localparam int          S  = 3;
  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          stall;
  logic          flush;
  logic [1:0]    occupancy;
`ifdef RISCV_PIPE_PARITY_EN
  logic          parity_err;
`endif

  int            errors = 0;
  int            checks = 0;
  logic [W-1:0]  exp_q [$];

  riscv_elastic_pipe #(.WIDTH(W), .STAGES(S), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall     (stall),
    .flush     (flush),
`ifdef RISCV_PIPE_PARITY_EN
    .parity_err(parity_err),
`endif
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== RV) begin errors++; $display("FAIL rst_out_data: got %h expected %h", out_data, RV); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occupancy: got %0d expected 0", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
`ifdef RISCV_PIPE_PARITY_EN
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rst_parity_err: got %b expected 0", parity_err); end
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_latency();
    int sent = 0, got = 0, first_acc = -1, first_out = -1, last_out = -1;
    logic [W-1:0] exp;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = (sent < 8);
      in_data   = 32'h10 + 32'(sent);
      @(negedge clk);
      if (out_valid && in_valid) begin
        checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL lat_occupancy: got %0d expected 3", occupancy); end
      end
      if (out_valid && out_ready && !stall) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL lat_data: got %h expected none", out_data); end
        else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin errors++; $display("FAIL lat_data: got %h expected %h", out_data, exp); end
        end
        if (first_out < 0) first_out = cyc;
        else begin
          checks++; if (cyc != last_out + 1) begin errors++; $display("FAIL lat_gap: got cycle %0d expected %0d", cyc, last_out + 1); end
        end
        last_out = cyc;
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      if (got == 8) break;
    end
    checks++; if (got != 8) begin errors++; $display("FAIL lat_count: got %0d expected 8", got); end
    checks++; if (first_out - first_acc != S) begin errors++; $display("FAIL lat_latency: got %0d expected %0d", first_out - first_acc, S); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] vals [3] = '{32'hA, 32'hB, 32'hC};
    logic [W-1:0] exp;
    int idx = 0;
    for (int cyc = 0; cyc < 20 && idx < 3; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = vals[idx];
      @(negedge clk);
      if (in_valid && in_ready) begin exp_q.push_back(in_data); idx++; end
    end
    checks++; if (idx != 3) begin errors++; $display("FAIL bp_fill: got %0d accepts expected 3", idx); end
    @(posedge clk); #1;
    in_data = 32'hD;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
    checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL bp_full_occ: got %0d expected 3", occupancy); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_refill_ready: got %b expected 1", in_ready); end
    checks++;
    if (!(out_valid && out_ready) || exp_q.size() == 0) begin errors++; $display("FAIL bp_release: got valid %b expected 1", out_valid); end
    else begin
      exp = exp_q.pop_front();
      if (out_data !== exp) begin errors++; $display("FAIL bp_release: got %h expected %h", out_data, exp); end
    end
    if (in_valid && in_ready) exp_q.push_back(in_data);
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      if (out_valid && out_ready && !stall) begin
        exp = exp_q.pop_front();
        checks++; if (out_data !== exp) begin errors++; $display("FAIL bp_drain: got %h expected %h", out_data, exp); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain_left: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_bubble();
    logic [W-1:0] exp;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk); #1;
      in_valid  = (cyc == 0 || cyc == 2);
      in_data   = (cyc == 0) ? 32'h1 : 32'h2;
      out_ready = (cyc >= 5);
      @(negedge clk);
      if (in_valid) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_accept: got %b expected 1", in_ready); end
        else exp_q.push_back(in_data);
      end
      if (cyc == 4) begin
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bub_occ: got %0d expected 2", occupancy); end
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h1) begin errors++; $display("FAIL bub_head: got %b/%h expected 1/00000001", out_valid, out_data); end
      end
      if (cyc == 5 || cyc == 6) begin
        checks++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin errors++; $display("FAIL bub_drain: got valid %b expected 1", out_valid); end
        else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin errors++; $display("FAIL bub_drain: got %h expected %h", out_data, exp); end
        end
      end
      if (cyc == 7) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bub_empty: got %b expected 0", out_valid); end
      end
    end
  endtask

  task automatic test_stall();
    int sent = 0, got = 0;
    logic [1:0]   snap_occ;
    logic [W-1:0] snap_data, exp;
    logic         snap_valid;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      stall     = (cyc >= 4 && cyc < 8);
      in_valid  = (sent < 12);
      in_data   = 32'h20 + 32'(sent);
      @(negedge clk);
      if (stall) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", in_ready); end
      end
      if (cyc == 4) begin snap_occ = occupancy; snap_data = out_data; snap_valid = out_valid; end
      if (cyc > 4 && cyc < 8) begin
        checks++;
        if (occupancy !== snap_occ || out_data !== snap_data || out_valid !== snap_valid) begin
          errors++; $display("FAIL stall_freeze: got %0d/%h/%b expected %0d/%h/%b", occupancy, out_data, out_valid, snap_occ, snap_data, snap_valid);
        end
      end
      if (out_valid && out_ready && !stall) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL stall_data: got %h expected none", out_data); end
        else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin errors++; $display("FAIL stall_data: got %h expected %h", out_data, exp); end
        end
        got++;
      end
      if (in_valid && in_ready) begin exp_q.push_back(in_data); sent++; end
      if (got == 12) break;
    end
    stall = 1'b0;
    checks++; if (got != 12 || exp_q.size() != 0) begin errors++; $display("FAIL stall_count: got %0d/%0d expected 12/0", got, exp_q.size()); end
  endtask

  task automatic test_flush();
    int idx = 0, seen = 0;
    for (int cyc = 0; cyc < 20 && idx < 3; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h30 + 32'(idx);
      @(negedge clk);
      if (in_valid && in_ready) begin exp_q.push_back(in_data); idx++; end
    end
    @(posedge clk); #1;
    flush    = 1'b1;
    stall    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hFF;
    @(negedge clk);
    checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL flush_pre_occ: got %0d expected 3", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    @(posedge clk); #1;
    flush    = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d expected 0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after_valid: got %b expected 0", out_valid); end
    exp_q.delete();
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_leak: got %0d outputs expected 0", seen); end
  endtask

  task automatic test_async_reset();
    int idx = 0, acc_cyc = -1, got = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = (idx < 2);
      in_data   = 32'h40 + 32'(idx);
      @(negedge clk);
      if (in_valid && in_ready) begin exp_q.push_back(in_data); idx++; end
    end
    checks++; if (out_valid !== 1'b1 || occupancy !== 2'd2) begin errors++; $display("FAIL arst_pre: got %b/%0d expected 1/2", out_valid, occupancy); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== RV) begin errors++; $display("FAIL arst_data: got %h expected %h", out_data, RV); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL arst_occ: got %0d expected 0", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL arst_ready: got %b expected 0", in_ready); end
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL arst_release: got %b/%b expected 1/0", in_ready, out_valid); end
    for (int cyc = 0; cyc < 15 && got == 0; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = (acc_cyc < 0);
      in_data   = 32'h50;
      @(negedge clk);
      if (out_valid && out_ready && !stall) begin
        checks++; if (out_data !== 32'h50) begin errors++; $display("FAIL arst_post_data: got %h expected 00000050", out_data); end
        checks++; if (cyc - acc_cyc != S) begin errors++; $display("FAIL arst_post_lat: got %0d expected %0d", cyc - acc_cyc, S); end
        got++;
      end
      if (in_valid && in_ready) acc_cyc = cyc;
    end
    checks++; if (got != 1) begin errors++; $display("FAIL arst_post_count: got %0d expected 1", got); end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    test_reset();
    test_latency();
    test_backpressure();
    test_bubble();
    test_stall();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
